uart_word_tx: RTL

- Parametrised multi-byte UART transmitter. It serialises an NBYTES-wide word as consecutive 8-bit UART frames, in selectable byte order, with optional parity and 1 or 2 stop bits.
- Runs entirely on the system clock. Baud timing comes from an internal clock-enable bit timer, not a derived clock.
- Takes words from upstream logic over a valid/ready handshake and drives the board TX pin.
- Successor to the fixed 2-byte, baud-clock-domain transmitter.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_bit_timer.sv | 32 +++
 rtl/uart_word_tx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the word-oriented UART transmitter and its future receiver.
// Holds the FSM state type, the parity encodings and the frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Start bit + 8 data bits + optional parity + 1 or 2 stop bits.
  function automatic int frame_bits(input int parity, input int stop_bits);
    return 10 + ((parity != PAR_NONE) ? 1 : 0) + (stop_bits - 1);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Clock-enable bit timer: reloads CLK_DIV-1 on load, counts down while enabled,
// and raises tick for the single cycle in which the count sits at zero.
module uart_bit_timer #(
  parameter int CLK_DIV = 406
) (
  input  logic sys_clk,
  input  logic sys_rst_l,
  input  logic load,
  input  logic enable,
  output logic tick
);

  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] RELOAD = TW'(CLK_DIV - 1);

  logic [TW-1:0] count;

  // NOTE: sequential state is always written with <= so every register samples
  // the pre-edge values of its neighbours, independent of process ordering.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tick = enable && (count == '0);

endmodule

// File: rtl/uart_word_tx.sv
// Multi-byte UART transmitter: serialises an NBYTES word as back-to-back 8-bit
// frames on the system clock, with selectable byte order, parity and stop bits.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int NBYTES    = 2,
  parameter int CLK_DIV   = 406,
  parameter int MSB_FIRST = 0,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_l,
  input  logic [8*NBYTES-1:0]   word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  serial_out,
  output logic                  byte_done,
  output logic                  word_done,
  output logic                  busy
);

  localparam int W          = 8 * NBYTES;
  localparam int FRAME_BITS = frame_bits(PARITY, STOP_BITS);
  localparam int BCW        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
  localparam logic [3:0]     LAST_POS  = 4'(FRAME_BITS - 1);
  localparam logic [3:0]     LAST_DATA = 4'd8;

  tx_state_e      state, state_n;
  logic [3:0]     pos, pos_n;
  logic [BCW-1:0] byte_cnt;
  logic [W-1:0]   word_sr;
  logic [7:0]     cur_byte;
  logic           par_bit;
  logic           line_n;
  logic           byte_done_n;
  logic           word_done_n;
  logic           accept;
  logic           next_byte;
  logic           tick;

  assign word_ready = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign accept     = word_ready && word_valid;

  // The byte on the wire always sits at the end of the shift register that
  // leaves first, so byte order is purely a matter of shift direction.
  assign cur_byte = (MSB_FIRST != 0) ? word_sr[W-1 -: 8] : word_sr[7:0];
  assign par_bit  = (PARITY == PAR_ODD) ? ~(^cur_byte) : (^cur_byte);

  uart_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .sys_clk   (sys_clk),
    .sys_rst_l (sys_rst_l),
    .load      (accept || tick),
    .enable    (busy),
    .tick      (tick)
  );

  // pos counts frame bits: 0 = start, 1..8 = data, then parity and stop bits.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    pos_n       = pos;
    line_n      = serial_out;
    byte_done_n = 1'b0;
    word_done_n = 1'b0;
    next_byte   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (word_valid) begin
          state_n = ST_START;
          pos_n   = 4'd0;
          line_n  = 1'b0;
        end
      end

      ST_START: begin
        if (tick) begin
          state_n = ST_DATA;
          pos_n   = pos + 4'd1;
          line_n  = cur_byte[pos[2:0]];
        end
      end

      ST_DATA: begin
        if (tick) begin
          pos_n = pos + 4'd1;
          if (pos == LAST_DATA) begin
            if (PARITY != PAR_NONE) begin
              state_n = ST_PARITY;
              line_n  = par_bit;
            end else begin
              state_n = ST_STOP;
              line_n  = 1'b1;
            end
          end else begin
            line_n = cur_byte[pos[2:0]];
          end
        end
      end

      ST_PARITY: begin
        if (tick) begin
          state_n = ST_STOP;
          pos_n   = pos + 4'd1;
          line_n  = 1'b1;
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (pos == LAST_POS) begin
            byte_done_n = 1'b1;
            if (byte_cnt == LAST_BYTE) begin
              state_n     = ST_IDLE;
              word_done_n = 1'b1;
              line_n      = 1'b1;
            end else begin
              state_n   = ST_START;
              pos_n     = 4'd0;
              line_n    = 1'b0;
              next_byte = 1'b1;
            end
          end else begin
            pos_n = pos + 4'd1;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
        line_n  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      state      <= ST_IDLE;
      pos        <= 4'd0;
      byte_cnt   <= '0;
      serial_out <= 1'b1;
      byte_done  <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      state      <= state_n;
      pos        <= pos_n;
      serial_out <= line_n;
      byte_done  <= byte_done_n;
      word_done  <= word_done_n;
      if (accept) begin
        byte_cnt <= '0;
      end else if (next_byte) begin
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

  // NOTE: the word shift register is pure datapath: it is always loaded on
  // accept before being read, so it carries no reset.
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      word_sr <= word_in;
    end else if (next_byte) begin
      word_sr <= (MSB_FIRST != 0) ? (word_sr << 8) : (word_sr >> 8);
    end
  end

endmodule
